// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: splits each fetched word into fields, builds the immediate and flags illegal encodings.
// Main register plus one skid entry give full throughput with a registered in_ready.
module rv32i_decode_stage #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [6:0]        out_opcode,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [2:0]        out_fmt,
    output logic [31:0]       out_imm,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_count
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_X = 3'd7;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [2:0]        fmt;
        logic [31:0]       imm;
        logic              illegal;
    } dec_t;

    function automatic dec_t decode_instr(input logic [31:0] instr, input logic [ADDR_W-1:0] pc);
        dec_t       d;
        logic [2:0] fmt;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       shift_imm;
        f3        = instr[14:12];
        f7        = instr[31:25];
        fmt       = FMT_X;
        shift_imm = 1'b0;
        // Words with instr[1:0] != 2'b11 never match a listed opcode and fall to illegal.
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: fmt = FMT_U;
            OPC_JAL:            fmt = FMT_J;
            OPC_JALR:           fmt = (f3 == 3'b000) ? FMT_I : FMT_X;
            OPC_BRANCH:         fmt = (f3 == 3'b010 || f3 == 3'b011) ? FMT_X : FMT_B;
            OPC_LOAD:           fmt = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ? FMT_X : FMT_I;
            OPC_STORE:          fmt = (f3 > 3'b010) ? FMT_X : FMT_S;
            OPC_OPIMM: begin
                if (f3 == 3'b001) begin
                    shift_imm = 1'b1;
                    fmt       = (f7 == F7_ZERO) ? FMT_I : FMT_X;
                end else if (f3 == 3'b101) begin
                    shift_imm = 1'b1;
                    fmt       = (f7 == F7_ZERO || f7 == F7_ALT) ? FMT_I : FMT_X;
                end else begin
                    fmt       = FMT_I;
                end
            end
            OPC_OP: begin
                if (f7 == F7_ZERO) begin
                    fmt = FMT_R;
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    fmt = FMT_R;
                end else begin
                    fmt = FMT_X;
                end
            end
            OPC_FENCE, OPC_SYSTEM: fmt = FMT_I;
            default:               fmt = FMT_X;
        endcase

        d         = '0;
        d.pc      = pc;
        d.opcode  = instr[6:0];
        d.fmt     = fmt;
        d.illegal = (fmt == FMT_X);
        case (fmt)
            FMT_R: begin
                d.rd     = instr[11:7];
                d.rs1    = instr[19:15];
                d.rs2    = instr[24:20];
                d.funct3 = f3;
                d.funct7 = f7;
            end
            FMT_I: begin
                d.rd     = instr[11:7];
                d.rs1    = instr[19:15];
                d.funct3 = f3;
                d.funct7 = shift_imm ? f7 : 7'd0;
                d.imm    = shift_imm ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
            end
            FMT_S: begin
                d.rs1    = instr[19:15];
                d.rs2    = instr[24:20];
                d.funct3 = f3;
                d.imm    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            FMT_B: begin
                d.rs1    = instr[19:15];
                d.rs2    = instr[24:20];
                d.funct3 = f3;
                d.imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            FMT_U: begin
                d.rd     = instr[11:7];
                d.imm    = {instr[31:12], 12'd0};
            end
            FMT_J: begin
                d.rd     = instr[11:7];
                d.imm    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin
                d.funct3 = f3;
            end
        endcase
        return d;
    endfunction

    dec_t             w_dec;
    dec_t             r_main;
    dec_t             r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_main_free;
    logic [CNT_W-1:0] r_cnt;

    // Combinational decode of the offered word.
    always_comb begin
        w_dec = decode_instr(in_instr, in_pc);
    end

    // A full skid entry is the only thing that blocks intake, so in_ready is a pure register output.
    assign in_ready    = ~r_skid_valid;
    assign w_in_hs     = in_valid & ~r_skid_valid;
    assign w_out_hs    = r_main_valid & out_ready;
    assign w_main_free = ~r_main_valid | out_ready;

    // Main/skid buffer: main drains to the consumer, skid absorbs one word while main stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_hs) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_hs) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    // Saturating count of illegal entries actually handed to the consumer; flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_out_hs && r_main.illegal && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid     = r_main_valid;
    assign out_pc        = r_main.pc;
    assign out_opcode    = r_main.opcode;
    assign out_rd        = r_main.rd;
    assign out_rs1       = r_main.rs1;
    assign out_rs2       = r_main.rs2;
    assign out_funct3    = r_main.funct3;
    assign out_funct7    = r_main.funct7;
    assign out_fmt       = r_main.fmt;
    assign out_imm       = r_main.imm;
    assign out_illegal   = r_main.illegal;
    assign illegal_count = r_cnt;

endmodule

// File: doc/rv32i_decode_stage.md
# rv32i_decode_stage

Registered RV32I instruction decode stage between the program-memory fetch path and the core's register-file and execute logic. It accepts 32-bit instruction words with their PC over a valid/ready handshake and splits each word into its fields. It produces a format-correct sign-extended immediate, flags illegal encodings, and counts them. A two-entry skid buffer gives full throughput and registered backpressure.

## Interface
- ADDR_W, 32, width of the PC carried alongside each instruction
- CNT_W, 16, width of the illegal-instruction counter
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  fetch offers a word
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready
- in_instr  in  32  instruction word
- in_pc  in  ADDR_W  address of in_instr
- out_valid  out  1  decoded entry available
- out_ready  in  1  consumer accepts
- out_pc  out  ADDR_W  PC of the entry
- out_opcode  out  7  instr[6:0]
- out_rd, out_rs1, out_rs2  out  5 each  register indices; zeroed when unused by the format
- out_funct3  out  3  instr[14:12]; 0 for U/J
- out_funct7  out  7  instr[31:25]; R format and shift-immediates only, else 0
- out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
- out_imm  out  32  sign-extended immediate
- out_illegal  out  1  entry is an illegal encoding
- illegal_count  out  CNT_W  saturating count of illegal entries delivered

## Operation
- Decode is combinational on in_instr. The decoded bundle is captured on an input handshake (in_valid & in_ready).
- Opcode map:
  - LUI 0110111 and AUIPC 0010111 → U.
  - JAL 1101111 → J.
  - JALR 1100111 → I; funct3 must be 000.
  - BRANCH 1100011 → B; funct3 010/011 are illegal.
  - LOAD 0000011 → I; funct3 011/110/111 are illegal.
  - STORE 0100011 → S; funct3 > 010 is illegal.
  - OP-IMM 0010011 → I. SLLI requires funct7=0000000. SRLI/SRAI require funct7 0000000/0100000.
  - OP 0110011 → R. funct7 0000000 is legal with any funct3. 0100000 is legal only with funct3 000/101. Any other funct7 is illegal.
  - FENCE 0001111 and SYSTEM 1110011 → I, legal.
  - Every other opcode is illegal, including any word with instr[1:0]≠11.
- Immediate by format:
  - I: sext(instr[31:20]); shift-immediates use zero-extended instr[24:20].
  - S: sext({instr[31:25],instr[11:7]}).
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  - U: {instr[31:12],12'b0}.
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  - R and illegal: 0.
- Field zeroing:
  - rd is 0 for S/B.
  - rs2 is 0 for I/U/J.
  - rs1 is 0 for U/J.
  - An illegal entry has fmt=7, all index fields 0 and imm 0. opcode, funct3 and pc pass through.
- Buffering:
  - The main register drives the outputs. The skid register catches a word accepted while the main register is stalled.
  - Order is strictly FIFO. No entry is dropped or duplicated.
- Counter: increments on an output handshake with out_illegal=1. It holds at all-ones and is not cleared by flush.

## Timing
- Reset values: out_valid=0, in_ready=1, every out_* field 0, illegal_count=0, both buffer entries empty.
- Latency is 1 cycle: a word accepted at edge N is presented with out_valid=1 after edge N.
- Throughput is 1 word/cycle while out_ready=1.
- Stall (out_valid & !out_ready): outputs stay stable. One further word is absorbed into the skid register, and in_ready goes low the following cycle.
- in_ready returns high the cycle after the skid entry moves to the main register.
- Output handshake together with input handshake in the same cycle: the main register reloads from the skid (if full) or from the input. There is no bubble.
- flush has the highest priority. Both entries are emptied at the next edge, a word offered in the same cycle is discarded, and in_ready=1 and out_valid=0 afterwards.
- rst asserted mid-stream returns all outputs to their reset values immediately and asynchronously.

## Test plan
- addi x3,x0,5 (0x00500193) → fmt=1, rd=3, rs1=0, rs2=0, imm=0x00000005, illegal=0, out_valid one cycle after accept.
- Stream add x5,x3,x4 (0x004182B3) then lui x2,0xFFFFF (0xFFFFF137), out_ready=1. Results in order:
  - fmt=0, rd=5, rs1=3, rs2=4, imm=0.
  - fmt=4, rd=2, imm=0xFFFFF000.
- jal x5,-12 (0xFF5FF2EF) → fmt=5, rd=5, imm=0xFFFFFFF4. beq x3,x4,0xF0 (0x0E418863) → fmt=3, rs1=3, rs2=4, rd=0, imm=0x000000F0.
- Words 0x00000000 and 0xFFFFFFFF with out_ready=1 → both give out_illegal=1, fmt=7, imm=0; illegal_count=2.
- Offer 4 consecutive words while out_ready is held low for 3 cycles → in_ready low after the 2nd accept. All 4 words emerge in order after release, none lost or repeated.
- With 2 entries buffered: assert flush → out_valid=0 and in_ready=1 next cycle. Assert rst while out_valid=1 → all outputs 0 and in_ready=1 immediately.
